// File: rtl/fp16_test_sequencer.sv
`timescale 1ns/1ps
// fp16_test_sequencer: walks a {A, B, expected} vector ROM through the FP16 adder and scores results.
// Optional FP16_SEQ_CLASS_EN splits failures into addition/subtraction counts.
module fp16_test_sequencer #(
    parameter int DEPTH   = 200,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [47:0]       rom_data,
    output logic [15:0]       op_a,
    output logic [15:0]       op_b,
    output logic              op_valid,
    input  logic              res_valid,
    input  logic [15:0]       res,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_count,
    output logic [15:0]       fail_count,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              first_fail_valid,
    output logic              timeout,
    output logic [15:0]       add_fail_count,
    output logic [15:0]       sub_fail_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_RES, CHECK, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       exp_q, res_q;
    logic [TW-1:0]     wait_cnt;
    logic              tmo_q;
    logic              run_start, last, pass, wait_end;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v + {15'd0, v != 16'hFFFF};
    endfunction

    assign run_start = (state == IDLE || state == DONE) && start;
    assign last      = idx == ADDR_W'(DEPTH - 1);
    assign pass      = !tmo_q && res_q == exp_q;
    assign wait_end  = wait_cnt == TW'(TIMEOUT - 1);
    assign rom_en    = state == FETCH;
    assign rom_addr  = idx;
    assign op_valid  = state == ISSUE;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? FETCH : state;
            FETCH:      state_nx = WAIT_ROM;
            WAIT_ROM:   state_nx = ISSUE;
            ISSUE:      state_nx = WAIT_RES;
            WAIT_RES:   state_nx = (res_valid || wait_end) ? CHECK : WAIT_RES;
            CHECK:      state_nx = last ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            idx              <= '0;
            op_a             <= '0;
            op_b             <= '0;
            exp_q            <= '0;
            res_q            <= '0;
            wait_cnt         <= '0;
            tmo_q            <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            state <= state_nx;
            if (run_start) begin
                idx              <= '0;
                pass_count       <= '0;
                fail_count       <= '0;
                first_fail_idx   <= '0;
                first_fail_valid <= 1'b0;
                timeout          <= 1'b0;
            end
            if (state == WAIT_ROM)
                {op_a, op_b, exp_q} <= rom_data;
            if (state == ISSUE)
                wait_cnt <= '0;
            // tmo_q is only consumed on the exit cycle, where it reflects a missing response
            if (state == WAIT_RES) begin
                wait_cnt <= wait_cnt + 1'b1;
                tmo_q    <= !res_valid;
                if (res_valid)
                    res_q <= res;
            end
            if (state == CHECK) begin
                if (pass) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    fail_count <= sat_inc(fail_count);
                    if (!first_fail_valid) begin
                        first_fail_idx   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                    if (tmo_q)
                        timeout <= 1'b1;
                end
                if (!last)
                    idx <= idx + 1'b1;
            end
        end
    end

`ifdef FP16_SEQ_CLASS_EN
    // Differing operand signs mean the adder performs an effective subtraction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            add_fail_count <= '0;
            sub_fail_count <= '0;
        end else if (run_start) begin
            add_fail_count <= '0;
            sub_fail_count <= '0;
        end else if (state == CHECK && !pass) begin
            if (op_a[15] != op_b[15])
                sub_fail_count <= sat_inc(sub_fail_count);
            else
                add_fail_count <= sat_inc(add_fail_count);
        end
    end
`else
    assign add_fail_count = '0;
    assign sub_fail_count = '0;
`endif

endmodule

// File: tb/tb_fp16_test_sequencer.sv
`timescale 1ns/1ps
// tb_fp16_test_sequencer: directed checks of the vector sequencer with a ROM model and a
// latency-configurable adder model.
module tb_fp16_test_sequencer;
    localparam int AW = 8;
`ifdef FP16_SEQ_CLASS_EN
    localparam logic [15:0] CL = 16'd1;
`else
    localparam logic [15:0] CL = 16'd0;
`endif

    logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic          rom_en, op_valid, res_valid, busy, done, first_fail_valid, timeout;
    logic [AW-1:0] rom_addr, first_fail_idx;
    logic [47:0]   rom_data = '0;
    logic [15:0]   op_a, op_b, res, pass_count, fail_count, add_fail_count, sub_fail_count;

    logic [47:0] rom [0:3];
    logic [15:0] ans [0:3];
    int          lat = 1, mute_idx = 0, cd = 0, cyc = 0, total = 0, bad = 0, gap;
    bit          mute = 1'b0;
    logic        rv_m = 1'b0, rv_man = 1'b0, pend = 1'b0;
    logic [15:0] res_m = '0, res_man = '0, pv = '0;

    assign res_valid = rv_m | rv_man;
    assign res       = rv_man ? res_man : res_m;

    always #5 clock = ~clock;

    fp16_test_sequencer #(.DEPTH(4), .ADDR_W(AW), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .res_valid(res_valid), .res(res),
        .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
        .timeout(timeout),
        .add_fail_count(add_fail_count), .sub_fail_count(sub_fail_count)
    );

    // ROM and adder models; the adder keeps its in-flight answer across a sequencer reset
    always @(posedge clock) begin
        if (rom_en) rom_data <= rom[rom_addr[1:0]];
        rv_m <= 1'b0;
        if (op_valid && !(mute && rom_addr == mute_idx)) begin
            if (lat == 1) begin
                rv_m  <= 1'b1;
                res_m <= ans[rom_addr[1:0]];
            end else begin
                pend <= 1'b1;
                cd   <= lat - 1;
                pv   <= ans[rom_addr[1:0]];
            end
        end else if (pend) begin
            if (cd == 1) begin
                rv_m  <= 1'b1;
                res_m <= pv;
                pend  <= 1'b0;
            end else cd <= cd - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done();
        while (!done && cyc < 400) step();
        chk("done reached", 64'(done), 64'd1);
    endtask

    task automatic wait_op(input int a);
        int n = 0;
        while (!(op_valid && (a < 0 || rom_addr == a)) && n < 100) begin
            step();
            n++;
        end
        chk("op_valid seen", 64'(op_valid), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, 64'({rom_en, rom_addr, op_a, op_b, op_valid, busy, done}), 64'd0);
        chk({tag, " stats"}, 64'({pass_count, fail_count, first_fail_idx, first_fail_valid, timeout}), 64'd0);
        chk({tag, " class"}, 64'({add_fail_count, sub_fail_count}), 64'd0);
    endtask

    initial begin
        rom[0] = {16'h3C00, 16'h3C00, 16'h4000};
        rom[1] = {16'h3C00, 16'hBC00, 16'h0000};
        rom[2] = {16'h4000, 16'h3C00, 16'h4200};
        rom[3] = {16'h4200, 16'hC000, 16'h3C00};
        for (int i = 0; i < 4; i++) ans[i] = rom[i][15:0];

        repeat (3) step();
        chk_zero("reset");
        reset = 1'b1;
        step();
        chk("idle after reset", 64'({busy, done, rom_en}), 64'd0);

        // all pass, L=1
        kick();
        chk("fetch after start", 64'({rom_en, busy, rom_addr}), {55'd0, 1'b1, 1'b1, 8'd0});
        wait_done();
        chk("allpass cycles", 64'(cyc), 64'd20);
        chk("allpass pass", 64'(pass_count), 64'd4);
        chk("allpass fail", 64'({fail_count, first_fail_valid, timeout}), 64'd0);
        chk("ops held", 64'({op_a, op_b}), 64'h4200C000);

        // single mismatch at vector 2; restart from DONE; start while busy ignored
        rom[2] = {16'h3C00, 16'h3C00, 16'h4000};
        ans[2] = 16'h4001;
        kick();
        chk("restart clears", 64'({pass_count, done}), 64'd0);
        repeat (6) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        chk("mismatch cycles", 64'(cyc), 64'd20);
        chk("mismatch pass", 64'(pass_count), 64'd3);
        chk("mismatch fail", 64'(fail_count), 64'd1);
        chk("mismatch first", 64'({first_fail_valid, first_fail_idx}), {55'd0, 1'b1, 8'd2});
        chk("mismatch timeout", 64'(timeout), 64'd0);
        chk("mismatch class", 64'({add_fail_count, sub_fail_count}), {32'd0, CL, 16'd0});

        // vector 0 times out, vector 1 mismatches as a subtraction
        rom[2] = {16'h4000, 16'h3C00, 16'h4200};
        ans[2] = 16'h4200;
        ans[1] = 16'h1234;
        mute = 1'b1;
        mute_idx = 0;
        kick();
        wait_op(0);
        gap = 0;
        while (!rom_en && gap < 100) begin
            step();
            gap++;
        end
        chk("timeout gap", 64'(gap), 64'd17);
        chk("next vector", 64'(rom_addr), 64'd1);
        wait_done();
        chk("timeout cycles", 64'(cyc), 64'd34);
        chk("timeout counts", 64'({pass_count, fail_count}), 64'h00020002);
        chk("timeout first", 64'({first_fail_valid, first_fail_idx}), {55'd0, 1'b1, 8'd0});
        chk("timeout flag", 64'(timeout), 64'd1);
        chk("timeout class", 64'({add_fail_count, sub_fail_count}), {32'd0, CL, CL});

        // spurious res_valid during ISSUE is ignored, L=2
        mute = 1'b0;
        ans[1] = 16'h0000;
        lat = 2;
        kick();
        wait_op(-1);
        rv_man = 1'b1;
        res_man = 16'hDEAD;
        step();
        rv_man = 1'b0;
        wait_done();
        chk("issue rv cycles", 64'(cyc), 64'd24);
        chk("issue rv counts", 64'({pass_count, fail_count}), 64'h00040000);
        chk("issue rv timeout", 64'(timeout), 64'd0);

        // reset mid-run at vector 3 with a response still in flight, L=3
        lat = 3;
        kick();
        wait_op(3);
        step();
        reset = 1'b0;
        #1;
        chk_zero("midrun reset");
        step();
        reset = 1'b1;
        step();
        step();
        chk("late rv ignored", 64'({busy, done, pass_count, fail_count}), 64'd0);
        lat = 1;
        kick();
        chk("rerun from 0", 64'({rom_en, rom_addr}), {55'd0, 1'b1, 8'd0});
        wait_done();
        chk("rerun cycles", 64'(cyc), 64'd20);
        chk("rerun counts", 64'({pass_count, fail_count}), 64'h00040000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp16_test_sequencer.md
# fp16_test_sequencer

Self-checking sequencer for the FP16 add/sub datapath (1 sign, 5 exponent, 10 mantissa bits). It walks a synchronous vector ROM of 48-bit words {A, B, expected}, issues each operand pair to the adder with a valid/response handshake, and compares the result bit-exactly against the expected value. It accumulates pass/fail statistics and flags completion, which makes it the hardware replacement for the simulation-only checker around the integrator.

## Interface
Parameters:
- `DEPTH`, 200, number of vectors in the ROM (1..2^ADDR_W).
- `ADDR_W`, 8, ROM address width.
- `TIMEOUT`, 15, maximum number of cycles spent in WAIT_RES before a vector is declared failed (≥1).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: level-sampled run request.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out ADDR_W: vector index.
- `rom_data` in 48: A=[47:32], B=[31:16], expected=[15:0]; valid the cycle after `rom_en`.
- `op_a`, `op_b` out 16: operands to the adder, held from ISSUE until the next ISSUE.
- `op_valid` out 1: one-cycle pulse in ISSUE.
- `res_valid` in 1: adder result strobe.
- `res` in 16: adder result.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `pass_count`, `fail_count` out 16: saturating counters.
- `first_fail_idx` out ADDR_W, `first_fail_valid` out 1: index of the first failing vector.
- `timeout` out 1: sticky; set by any vector that times out.
- `add_fail_count`, `sub_fail_count` out 16: see Configuration.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH (`rom_en`=1, `rom_addr`=idx) → WAIT_ROM.
  - WAIT_ROM (capture `rom_data` into the A/B/expected registers) → ISSUE.
  - ISSUE (`op_valid`=1) → WAIT_RES.
  - WAIT_RES → CHECK on `res_valid`, or on the TIMEOUT-th cycle in this state with no `res_valid`.
  - CHECK → FETCH if idx<DEPTH-1 (idx increments), else DONE.
  - DONE → FETCH on `start`.
- Entering FETCH from IDLE or DONE clears idx, all counters, `first_fail_*` and `timeout`.
- CHECK behaviour:
  - Pass when the captured `res` is bit-identical to expected. There is no NaN or ±0 equivalence.
  - On a pass, `pass_count` increments.
  - On a fail or timeout, `fail_count` increments. If `first_fail_valid`=0, `first_fail_idx` is set to idx and `first_fail_valid` is set to 1.
  - A timed-out vector is a fail and sets `timeout`=1.
- `res` is sampled on the edge where `res_valid`=1 in WAIT_RES. `res_valid` in any other state, including the ISSUE cycle itself, is ignored.
- `start` while `busy` is ignored.
- Counters saturate at 0xFFFF and never wrap.
- Asserting `reset` mid-run immediately forces IDLE and zeroes all outputs and registers. An in-flight adder response after reset is ignored.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `start` sampled high in IDLE puts `rom_en` high in the next cycle.
- With adder latency L (`res_valid` L≥1 cycles after the `op_valid` cycle), one vector takes 4+L cycles, from FETCH to the next FETCH or to DONE.
- L=1 gives a 5-cycle cadence per vector.
- A full run takes DEPTH·(4+L) cycles after the cycle that samples `start`.
- Counters and `first_fail_*` update on the edge leaving CHECK. They are stable when `done` rises.
- A timeout exits WAIT_RES after exactly TIMEOUT cycles in that state.
- `op_a`/`op_b` change only on the edge entering ISSUE.

## Configuration
- Macro `FP16_SEQ_CLASS_EN`.
- When defined:
  - Each failing vector is classified as a subtraction if A[15]≠B[15], otherwise as an addition.
  - `sub_fail_count` or `add_fail_count` increments accordingly (saturating, and cleared on run start).
  - The two counts always sum to `fail_count` while below saturation.
- When undefined, `add_fail_count` and `sub_fail_count` are tied to 0 and the classification logic is absent.

## Test plan
- Reset check: drive `reset`=0 mid-run at vector 3 → all outputs are 0, the state is IDLE, and a late `res_valid` is ignored. A later `start` runs from idx 0.
- All-pass run: DEPTH=4, model L=1, every expected value correct → `done` rises 20 cycles after the cycle that samples `start`, with `pass_count`=4, `fail_count`=0 and `first_fail_valid`=0.
- Single mismatch: vector 2 expected=0x4000 while the adder returns 0x4001 → `fail_count`=1, `pass_count`=3, `first_fail_idx`=2, `timeout`=0.
- Timeout: the adder never answers vector 0, with TIMEOUT=15 → WAIT_RES lasts 15 cycles, `fail_count`=1, `timeout`=1, and the run continues to vector 1.
- Handshake rules: `start` pulsed while `busy` → no effect. `start` in DONE → counters clear and the run restarts. `res_valid` asserted in the ISSUE cycle → ignored.
- Macro on: the A=0x3C00, B=0xBC00 vector fails → `sub_fail_count`=1. The A=0x3C00, B=0x3C00 vector fails → `add_fail_count`=1. With the macro off, both ports read 0.
